// File: rtl/fifo_row_pair_reader_pkg.sv
// fifo_row_pair_reader shared types.
// State encoding and index-width helper for stream stages.
package fifo_row_pair_reader_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRIME = 3'd1;
   localparam logic [2:0] S_PAIR  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_PRIME = S_PRIME,
      ST_PAIR  = S_PAIR,
      ST_DRAIN = S_DRAIN,
      ST_DONE  = S_DONE
   } state_e;

   localparam int BUF_DEPTH = 2;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_row_pair_reader_if.sv
// fifo_row_pair_reader port bundle.
// master = row-pair reader, slave = FIFO plus downstream stage.
interface fifo_row_pair_reader_if #(
   parameter int DATA_WIDTH = 128,
   parameter int COL_W      = 9,
   parameter int ROW_W      = 8
);
   logic                  start;
   logic                  busy;
   logic                  frame_done;
   logic [DATA_WIDTH-1:0] fifo_rd_data_a;
   logic [DATA_WIDTH-1:0] fifo_rd_data_b;
   logic                  fifo_empty_a;
   logic                  fifo_empty_b;
   logic                  fifo_wr_en;
   logic                  fifo_rd_en_a;
   logic                  fifo_rd_en_b;
   logic [DATA_WIDTH-1:0] o_data_top;
   logic [DATA_WIDTH-1:0] o_data_bot;
   logic [COL_W-1:0]      o_col;
   logic [ROW_W-1:0]      o_row;
   logic                  o_last_col;
   logic                  o_valid;
   logic                  o_ready;

   modport master (
      input  start, fifo_rd_data_a, fifo_rd_data_b,
      input  fifo_empty_a, fifo_empty_b, fifo_wr_en, o_ready,
      output busy, frame_done, fifo_rd_en_a, fifo_rd_en_b,
      output o_data_top, o_data_bot, o_col, o_row,
      output o_last_col, o_valid
   );

   modport slave (
      output start, fifo_rd_data_a, fifo_rd_data_b,
      output fifo_empty_a, fifo_empty_b, fifo_wr_en, o_ready,
      input  busy, frame_done, fifo_rd_en_a, fifo_rd_en_b,
      input  o_data_top, o_data_bot, o_col, o_row,
      input  o_last_col, o_valid
   );
endinterface

// File: rtl/fifo_row_pair_reader_skid.sv
// pair_skid_buffer: 2-entry register FIFO for tagged pairs.
// Occupancy is exported so the issuer can budget credits.
module pair_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0] e0_q, e0_d;
   logic [WIDTH-1:0] e1_q, e1_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             push, pop;

   assign pop  = out_ready & (cnt_q != 2'd0);
   assign push = in_valid & (cnt_q != 2'd2);

   // Head/tail shifting; a push with a pop only happens at depth 1.
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = in_data;
            else               e1_d = in_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: e0_d = in_data;
         default: ;
      endcase
   end

   // Entry and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = e0_q;
   assign occupancy = cnt_q;

endmodule

// File: rtl/fifo_row_pair_reader.sv
// fifo_row_pair_reader: reads row r on port A, row r+1 on port B.
// Emits vertical pairs; bottom row is zero-padded.
module fifo_row_pair_reader
   import fifo_row_pair_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ROW_LEN    = 512,
   parameter int NUM_ROWS   = 256
) (
   input logic                    clk,
   input logic                    rst_n,
   fifo_row_pair_reader_if.master bus
);

   localparam int COL_W = idx_w(ROW_LEN);
   localparam int ROW_W = idx_w(NUM_ROWS);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_LEN - 1);
   localparam logic [ROW_W-1:0] ROW_PMAX = ROW_W'(NUM_ROWS - 2);

   typedef struct packed {
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic             last_col;
      logic             pad;
   } tag_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] top;
      logic [DATA_WIDTH-1:0] bot;
      tag_t                  tag;
   } entry_t;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             fly_q, fly_d;
   tag_t             tag_q, tag_d;

   logic [1:0] occ;
   logic [2:0] used;
   logic       pop, credit_ok;
   logic       rd_a, rd_b, issue, col_wrap;
   entry_t     push_e, head_e;

   assign pop       = bus.o_valid & bus.o_ready;
   assign used      = {1'b0, occ} + {2'b0, fly_q};
   assign credit_ok = used < (3'd2 + {2'b0, pop});
   assign col_wrap  = (col_q == COL_MAX);

   // Read enables: gated by write collision, empties and credits.
   always_comb begin
      rd_a = 1'b0;
      rd_b = 1'b0;
      unique case (state_q)
         ST_PRIME: rd_b = ~bus.fifo_empty_b & ~bus.fifo_wr_en;
         ST_PAIR: begin
            rd_a = ~bus.fifo_empty_a & ~bus.fifo_empty_b
                 & ~bus.fifo_wr_en & credit_ok;
            rd_b = rd_a;
         end
         ST_DRAIN: rd_a = ~bus.fifo_empty_a & ~bus.fifo_wr_en
                        & credit_ok;
         default: ;
      endcase
   end

   assign issue = rd_a | rd_b;

   // Frame sequencing, position counters and in-flight tag.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      fly_d   = 1'b0;
      tag_d   = tag_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_PRIME;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ST_PRIME: begin
            if (issue) begin
               col_d = col_wrap ? '0 : col_q + 1'b1;
               if (col_wrap) state_d = ST_PAIR;
            end
         end
         ST_PAIR, ST_DRAIN: begin
            if (issue) begin
               fly_d = 1'b1;
               tag_d = '{col_q, row_q, col_wrap,
                         state_q == ST_DRAIN};
               col_d = col_wrap ? '0 : col_q + 1'b1;
               if (col_wrap) begin
                  if (state_q == ST_DRAIN) begin
                     state_d = ST_DONE;
                     row_d   = '0;
                  end else begin
                     row_d = row_q + 1'b1;
                     if (row_q == ROW_PMAX) state_d = ST_DRAIN;
                  end
               end
            end
         end
         ST_DONE: begin
            if (occ == 2'd0 && !fly_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM, counters and in-flight registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         fly_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         col_q   <= col_d;
         row_q   <= row_d;
         fly_q   <= fly_d;
         tag_q   <= tag_d;
      end
   end

   assign push_e.top = bus.fifo_rd_data_a;
   assign push_e.bot = tag_q.pad ? '0 : bus.fifo_rd_data_b;
   assign push_e.tag = tag_q;

   pair_skid_buffer #(
      .WIDTH($bits(entry_t))
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fly_q),
      .in_data   (push_e),
      .out_ready (bus.o_ready),
      .out_valid (bus.o_valid),
      .out_data  (head_e),
      .occupancy (occ)
   );

   assign bus.fifo_rd_en_a = rd_a;
   assign bus.fifo_rd_en_b = rd_b;
   assign bus.busy         = busy_q;
   assign bus.o_data_top   = head_e.top;
   assign bus.o_data_bot   = head_e.bot;
   assign bus.o_col        = head_e.tag.col;
   assign bus.o_row        = head_e.tag.row;
   assign bus.o_last_col   = head_e.tag.last_col;
   assign bus.frame_done   = pop & head_e.tag.pad
                           & head_e.tag.last_col;

endmodule

// File: tb/tb_fifo_row_pair_reader.sv
// Scoreboard bench for fifo_row_pair_reader.
// Expected pairs come from the preloaded frame contents.
module tb_fifo_row_pair_reader;

   localparam int DW = 16;
   localparam int RL = 4;
   localparam int NR = 3;
   localparam int TOTAL = RL * NR;
   localparam int CW = 2;
   localparam int RW = 2;

   localparam int M_BASIC = 0;
   localparam int M_BP    = 1;
   localparam int M_COLL  = 2;
   localparam int M_STALL = 3;
   localparam int M_ABUSE = 4;
   localparam int M_RESET = 5;
   localparam int M_RAND  = 6;

   typedef struct {
      logic [DW-1:0] top;
      logic [DW-1:0] bot;
      int            col;
      int            row;
      bit            last;
      bit            done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_row_pair_reader_if #(
      .DATA_WIDTH(DW), .COL_W(CW), .ROW_W(RW)
   ) bus ();

   fifo_row_pair_reader #(
      .DATA_WIDTH(DW), .ROW_LEN(RL), .NUM_ROWS(NR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] mem [TOTAL];
   int            pa, pb;
   logic [DW-1:0] da, db;
   logic          force_ea, force_eb, rewind;

   // Line FIFO model: two read pointers, 1-cycle read latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pa <= 0; pb <= 0; da <= '0; db <= '0;
      end else if (rewind) begin
         pa <= 0; pb <= 0;
      end else if (!bus.fifo_wr_en) begin
         if (bus.fifo_rd_en_a && pa < TOTAL) begin
            da <= mem[pa]; pa <= pa + 1;
         end
         if (bus.fifo_rd_en_b && pb < TOTAL) begin
            db <= mem[pb]; pb <= pb + 1;
         end
      end
   end

   assign bus.fifo_empty_a   = (pa >= TOTAL) | force_ea;
   assign bus.fifo_empty_b   = (pb >= TOTAL) | force_eb;
   assign bus.fifo_rd_data_a = da;
   assign bus.fifo_rd_data_b = db;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   int   hs_cnt, hs_first, hs_last;
   int   n_bo, n_pr, n_ao;
   bit   done_seen, chk_stall, hold_v;
   logic [DW-1:0] h_top, h_bot;
   logic [CW-1:0] h_col;
   logic [RW-1:0] h_row;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [63:0] act,
                                 logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard on each output handshake.
   initial forever begin
      exp_t e;
      logic acc_a, acc_b;
      @(negedge clk);
      if (!rst_n) begin
         hold_v = 1'b0;
         continue;
      end
      if (hold_v) begin
         check("hold_valid", bus.o_valid, 1);
         check("hold_top", bus.o_data_top, h_top);
         check("hold_bot", bus.o_data_bot, h_bot);
         check("hold_col", bus.o_col, h_col);
         check("hold_row", bus.o_row, h_row);
      end
      hold_v = bus.o_valid & ~bus.o_ready;
      h_top = bus.o_data_top; h_bot = bus.o_data_bot;
      h_col = bus.o_col;      h_row = bus.o_row;
      check("rd_a_gate", bus.fifo_rd_en_a
            & (bus.fifo_empty_a | bus.fifo_wr_en), 0);
      check("rd_b_gate", bus.fifo_rd_en_b
            & (bus.fifo_empty_b | bus.fifo_wr_en), 0);
      if (chk_stall) begin
         check("stall_rd_a", bus.fifo_rd_en_a, 0);
         check("stall_rd_b", bus.fifo_rd_en_b, 0);
      end
      if (bus.o_valid && bus.o_ready) begin
         check("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("top", bus.o_data_top, e.top);
            check("bot", bus.o_data_bot, e.bot);
            check("col", bus.o_col, e.col);
            check("row", bus.o_row, e.row);
            check("last_col", bus.o_last_col, e.last);
            check("frame_done", bus.frame_done, e.done);
         end
         if (bus.frame_done) done_seen = 1'b1;
         if (hs_cnt == 0) hs_first = cyc;
         hs_last = cyc;
         hs_cnt++;
      end else begin
         check("frame_done_idle", bus.frame_done, 0);
      end
      acc_a = bus.fifo_rd_en_a & ~bus.fifo_wr_en;
      acc_b = bus.fifo_rd_en_b & ~bus.fifo_wr_en;
      if (acc_a && acc_b) n_pr++;
      else if (acc_a)     n_ao++;
      else if (acc_b)     n_bo++;
      check("credit_bound", (n_pr + n_ao - hs_cnt) <= 2, 1);
   end

   task automatic fill(input bit rnd);
      for (int i = 0; i < TOTAL; i++)
         mem[i] = rnd ? DW'($urandom)
                      : DW'((i / RL) * 16 + (i % RL));
   endtask

   task automatic push_frame();
      exp_t e;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < RL; c++) begin
            e.top  = mem[r * RL + c];
            e.bot  = (r < NR - 1) ? mem[(r + 1) * RL + c] : '0;
            e.col  = c;
            e.row  = r;
            e.last = (c == RL - 1);
            e.done = (r == NR - 1) && (c == RL - 1);
            exp_q.push_back(e);
         end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_frame_done"}, bus.frame_done, 0);
      check({tag, "_rd_en_a"}, bus.fifo_rd_en_a, 0);
      check({tag, "_rd_en_b"}, bus.fifo_rd_en_b, 0);
      check({tag, "_o_valid"}, bus.o_valid, 0);
      check({tag, "_o_top"}, bus.o_data_top, 0);
      check({tag, "_o_bot"}, bus.o_data_bot, 0);
      check({tag, "_o_col"}, bus.o_col, 0);
      check({tag, "_o_row"}, bus.o_row, 0);
   endtask

   task automatic run_frame(input int mode, input int limit);
      push_frame();
      hs_cnt = 0; n_bo = 0; n_pr = 0; n_ao = 0;
      hs_first = 0; hs_last = 0; done_seen = 1'b0;
      rewind = 1'b1;
      @(posedge clk); #1;
      rewind = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);
      for (int i = 0; i < limit && !done_seen; i++) begin
         case (mode)
            M_ABUSE: bus.start = (i == 1 || i == 6);
            M_BP:    bus.o_ready = !(i >= 7 && i < 17);
            M_COLL:  bus.fifo_wr_en = (i % 2 == 0);
            M_STALL: begin
               force_eb  = (i >= 6 && i < 11);
               chk_stall = force_eb;
            end
            M_RAND: begin
               bus.o_ready    = ($urandom_range(0, 3) != 0);
               bus.fifo_wr_en = ($urandom_range(0, 3) == 0);
               force_ea       = ($urandom_range(0, 7) == 0);
               force_eb       = ($urandom_range(0, 7) == 0);
            end
            default: ;
         endcase
         if (mode == M_RESET && hs_cnt >= 6) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.o_ready = 1'b1; bus.fifo_wr_en = 1'b0;
      force_ea = 1'b0; force_eb = 1'b0; chk_stall = 1'b0;
      check("frame_timeout", done_seen, 1);
      repeat (4) @(posedge clk);
      #1;
      check("busy_end", bus.busy, 0);
      check("queue_drained", exp_q.size(), 0);
      check("reads_b_only", n_bo, RL);
      check("reads_paired", n_pr, (NR - 1) * RL);
      check("reads_a_only", n_ao, RL);
      if (mode == M_BASIC)
         check("span_basic", hs_last - hs_first, TOTAL - 1);
      if (mode == M_COLL)
         check("span_collision", hs_last - hs_first, 2 * (TOTAL - 1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.fifo_wr_en = 1'b0; bus.o_ready = 1'b1;
      force_ea = 1'b0; force_eb = 1'b0;
      rewind = 1'b0; chk_stall = 1'b0; hold_v = 1'b0;
      hs_cnt = 0; n_bo = 0; n_pr = 0; n_ao = 0;
      fill(1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(M_BASIC, 100);
      run_frame(M_BP, 100);
      run_frame(M_COLL, 100);
      run_frame(M_STALL, 100);
      run_frame(M_ABUSE, 100);
      run_frame(M_RESET, 100);
      run_frame(M_BASIC, 100);
      for (int k = 0; k < 3; k++) begin
         fill(1'b1);
         run_frame(M_RAND, 600);
      end
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
